// File: rtl/calendar_scan_if.sv
// Bus between the calendar core and the display scan stage: BCD value, strobes,
// and the multiplexed segment/enable lines for both seven-segment banks.
interface calendar_scan_if;
  logic [31:0] data;
  logic [7:0]  dp;
  logic [7:0]  blink_mask;
  logic        lzs;
  logic        load;
  logic [7:0]  a_to_g_left;
  logic [7:0]  a_to_g_right;
  logic [3:0]  leftseg;
  logic [3:0]  rightseg;

  modport master (
    output data, dp, blink_mask, lzs, load,
    input  a_to_g_left, a_to_g_right, leftseg, rightseg
  );

  modport slave (
    input  data, dp, blink_mask, lzs, load,
    output a_to_g_left, a_to_g_right, leftseg, rightseg
  );
endinterface

// File: rtl/calendar_scan.sv
// Time-multiplexes eight double-buffered BCD digits onto two 4-digit seven-segment
// banks, with per-bank leading-zero suppression, per-digit blink and decimal points.
module calendar_scan #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 125
) (
  input logic             clk,
  input logic             reset,
  calendar_scan_if.slave  bus
);

  localparam int CntW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CntW-1:0]   ScanLast  = CntW'(SCAN_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_FRAMES - 1);

  logic [CntW-1:0]   presc_q, presc_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       pendData_q, pendData_d, dispData_q, dispData_d;
  logic [7:0]        pendDp_q, pendDp_d, dispDp_q, dispDp_d;
  logic [7:0]        pendBlink_q, pendBlink_d, dispBlink_q, dispBlink_d;
  logic [BlinkW-1:0] blinkCnt_q, blinkCnt_d;
  logic              blinkPhase_q, blinkPhase_d;
  logic [7:0]        segLeft_q, segLeft_d, segRight_q, segRight_d;
  logic [3:0]        enLeft_q, enLeft_d, enRight_q, enRight_d;

  logic       tick, frameEdge;
  logic [1:0] bankPos;
  logic [3:0] digLeft, digRight, lzLeft, lzRight;
  logic       blankLeft, blankRight;

  // Segment order a..g; any non-BCD code shows a dash.
  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'd0:    decode = 7'b1111110;
      4'd1:    decode = 7'b0110000;
      4'd2:    decode = 7'b1101101;
      4'd3:    decode = 7'b1111001;
      4'd4:    decode = 7'b0110011;
      4'd5:    decode = 7'b1011011;
      4'd6:    decode = 7'b1011111;
      4'd7:    decode = 7'b1110000;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1111011;
      default: decode = 7'b0000001;
    endcase
  endfunction

  // Bit p set when bank position p and everything above it is zero; position 0 always shows.
  function automatic logic [3:0] leadZeros(input logic [15:0] bank);
    logic [3:0] lz;
    lz[3] = (bank[15:12] == 4'd0);
    lz[2] = lz[3] && (bank[11:8] == 4'd0);
    lz[1] = lz[2] && (bank[7:4] == 4'd0);
    lz[0] = 1'b0;
    return lz;
  endfunction

  always_comb begin
    tick      = (presc_q == ScanLast);
    frameEdge = tick && (idx_q == 2'd3);
    bankPos   = 2'd3 - idx_q;

    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = tick ? idx_q + 2'd1 : idx_q;

    pendData_d  = bus.load ? bus.data       : pendData_q;
    pendDp_d    = bus.load ? bus.dp         : pendDp_q;
    pendBlink_d = bus.load ? bus.blink_mask : pendBlink_q;

    // Display copies the pending value as it stood before this edge, so a
    // coincident load only appears from the following frame.
    dispData_d  = frameEdge ? pendData_q  : dispData_q;
    dispDp_d    = frameEdge ? pendDp_q    : dispDp_q;
    dispBlink_d = frameEdge ? pendBlink_q : dispBlink_q;

    blinkCnt_d   = blinkCnt_q;
    blinkPhase_d = blinkPhase_q;
    if (frameEdge) begin
      if (blinkCnt_q == BlinkLast) begin
        blinkCnt_d   = '0;
        blinkPhase_d = ~blinkPhase_q;
      end else begin
        blinkCnt_d = blinkCnt_q + 1'b1;
      end
    end

    digLeft  = dispData_q[{1'b1, bankPos, 2'b00} +: 4];
    digRight = dispData_q[{1'b0, bankPos, 2'b00} +: 4];
    lzLeft   = leadZeros(dispData_q[31:16]);
    lzRight  = leadZeros(dispData_q[15:0]);

    blankLeft  = (blinkPhase_q && dispBlink_q[{1'b1, bankPos}]) || (bus.lzs && lzLeft[bankPos]);
    blankRight = (blinkPhase_q && dispBlink_q[{1'b0, bankPos}]) || (bus.lzs && lzRight[bankPos]);

    segLeft_d  = blankLeft  ? 8'h00 : {decode(digLeft),  dispDp_q[{1'b1, bankPos}]};
    segRight_d = blankRight ? 8'h00 : {decode(digRight), dispDp_q[{1'b0, bankPos}]};
    enLeft_d   = 4'b0001 << bankPos;
    enRight_d  = 4'b0001 << bankPos;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pendData_q   <= '0;
      pendDp_q     <= '0;
      pendBlink_q  <= '0;
      dispData_q   <= '0;
      dispDp_q     <= '0;
      dispBlink_q  <= '0;
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
      segLeft_q    <= '0;
      segRight_q   <= '0;
      enLeft_q     <= '0;
      enRight_q    <= '0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pendData_q   <= pendData_d;
      pendDp_q     <= pendDp_d;
      pendBlink_q  <= pendBlink_d;
      dispData_q   <= dispData_d;
      dispDp_q     <= dispDp_d;
      dispBlink_q  <= dispBlink_d;
      blinkCnt_q   <= blinkCnt_d;
      blinkPhase_q <= blinkPhase_d;
      segLeft_q    <= segLeft_d;
      segRight_q   <= segRight_d;
      enLeft_q     <= enLeft_d;
      enRight_q    <= enRight_d;
    end
  end

  assign bus.a_to_g_left  = segLeft_q;
  assign bus.a_to_g_right = segRight_q;
  assign bus.leftseg      = enLeft_q;
  assign bus.rightseg     = enRight_q;

endmodule
